// File: rtl/openfire_prefetch_pkg.sv
// openfire_prefetch_pkg: constants shared by the prefetch buffer and its bench.
// Carries the address-space width and the no-op instruction word that the
// core's define file normally provides.
package openfire_prefetch_pkg;

  // Word address space; byte PCs are two bits wider.
  localparam int A_SPACE = 10;
  localparam int PC_W_DEFAULT = A_SPACE + 2;

  // "or r0, r0, r0" -- what fetch sees when nothing is buffered.
  localparam logic [31:0] NOOP = 32'h8000_0000;

endpackage

// File: rtl/openfire_prefetch_if.sv
// openfire_prefetch_if: instruction-memory read channel.
// The prefetch buffer is the master, the memory wrapper is the slave.
// imem_addr/imem_re stay stable until imem_ack has been sampled high.
interface openfire_prefetch_if;

  logic [31:0] imem_addr;
  logic        imem_re;
  logic [31:0] imem_data;
  logic        imem_ack;

  modport master (
    output imem_addr,
    output imem_re,
    input  imem_data,
    input  imem_ack
  );

  modport slave (
    input  imem_addr,
    input  imem_re,
    output imem_data,
    output imem_ack
  );

endinterface

// File: rtl/openfire_prefetch_fifo.sv
// openfire_prefetch_fifo: small synchronous FIFO with flush.
// Head entry is visible combinationally; the caller must never push when
// full nor pop when empty.
module openfire_prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 44
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/openfire_prefetch.sv
// openfire_prefetch: sequential instruction prefetch buffer for openfire_fetch.
// Reads words ahead of the core into a FIFO tagged with their PCs. A taken
// branch flushes the FIFO; a read already in flight is allowed to finish
// (its data thrown away) before fetching resumes at the branch target.
module openfire_prefetch
  import openfire_prefetch_pkg::*;
#(
  parameter int PC_W  = PC_W_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                branch_taken,
  input  logic [PC_W-1:0]     pc_branch,
  input  logic                consume,
  openfire_prefetch_if.master imem,
  output logic [31:0]         instruction,
  output logic [PC_W-1:0]     instr_pc,
  output logic                instr_valid
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [PC_W-1:0]   req_addr;
  logic [PC_W-1:0]   redirect;
  logic [PC_W-1:0]   target;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_after_pop;
  logic [CNT_W-1:0]  count_next;
  logic [PC_W+31:0]  head;
  logic              push;
  logic              pop;
  logic              room;
  logic              room_after;

  assign target = pc_branch & ~PC_W'(3);

  // A branch flushes the FIFO, so neither a pop nor a push may land that edge.
  assign pop  = consume & instr_valid & ~branch_taken;
  assign push = (state == REQ) & imem.imem_ack & ~branch_taken;

  assign count_after_pop = count - CNT_W'(pop);
  assign count_next      = count_after_pop + CNT_W'(push);
  assign room            = count_after_pop < CNT_W'(DEPTH);
  assign room_after      = count_next < CNT_W'(DEPTH);

  openfire_prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PC_W + 32)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (branch_taken),
    .push  (push),
    .pop   (pop),
    .din   ({req_addr, imem.imem_data}),
    .head  (head),
    .count (count)
  );

  // Request sequencer: issues reads while there is room, and on a branch
  // either redirects at once or first drains the read still outstanding.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      req_addr <= '0;
      redirect <= '0;
    end else if (branch_taken) begin
      if (state != IDLE && imem.imem_ack) begin
        req_addr <= target;
        state    <= REQ;
      end else if (state == REQ) begin
        redirect <= target;
        state    <= DRAIN;
      end else if (state == DRAIN) begin
        redirect <= target;
      end else begin
        req_addr <= target;
        state    <= REQ;
      end
    end else begin
      case (state)
        IDLE: begin
          if (room) begin
            state <= REQ;
          end
        end
        REQ: begin
          if (imem.imem_ack) begin
            req_addr <= req_addr + PC_W'(4);
            state    <= room_after ? REQ : IDLE;
          end
        end
        DRAIN: begin
          if (imem.imem_ack) begin
            req_addr <= redirect;
            state    <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign imem.imem_re   = (state != IDLE);
  assign imem.imem_addr = 32'(req_addr);

  assign instr_valid = (count != '0);
  assign instruction = instr_valid ? head[31:0] : NOOP;
  assign instr_pc    = instr_valid ? head[PC_W+31:32] : '0;

endmodule

// File: tb/tb_openfire_prefetch.sv
// tb_openfire_prefetch: scoreboard bench for the prefetch buffer.
// Stimulus queues the PCs it expects fetch to receive; a monitor pops and
// compares them whenever fetch accepts a head entry.
module tb_openfire_prefetch;
  import openfire_prefetch_pkg::*;

  localparam int PC_W  = PC_W_DEFAULT;
  localparam int DEPTH = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            branch_taken;
  logic [PC_W-1:0] pc_branch;
  logic            consume;
  logic [31:0]     instruction;
  logic [PC_W-1:0] instr_pc;
  logic            instr_valid;

  openfire_prefetch_if imem_bus ();

  openfire_prefetch #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .branch_taken (branch_taken),
    .pc_branch    (pc_branch),
    .consume      (consume),
    .imem         (imem_bus),
    .instruction  (instruction),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int wait_n = 0;
  int wcnt   = 0;

  logic [PC_W-1:0] exp_q[$];
  int              pop_cyc[$];
  logic [PC_W-1:0] exp_pc;
  logic            prev_re   = 1'b0;
  logic            prev_ack  = 1'b0;
  logic [31:0]     prev_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 | {20'h0, a[11:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic c, input logic b, input logic [PC_W-1:0] pc);
    consume      = c;
    branch_taken = b;
    pc_branch    = pc;
  endtask

  task automatic applyReset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, '0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic pushRange(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(PC_W'(start + 4 * i));
    end
  endtask

  task automatic drainQueue(input int limit);
    int n = 0;
    consume = 1'b1;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clock);
      n++;
    end
    #1;
    consume = 1'b0;
    checkOutput("drain_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Cycle counter used to measure pop spacing.
  always @(posedge clock) begin
    cycle <= cycle + 1;
  end

  // Memory model: acks after wait_n extra cycles, data derived from address.
  always @(posedge clock) begin
    if (imem_bus.imem_re && imem_bus.imem_ack) begin
      wcnt = 0;
    end else if (imem_bus.imem_re) begin
      wcnt = wcnt + 1;
    end else begin
      wcnt = 0;
    end
    #2;
    imem_bus.imem_ack  = imem_bus.imem_re && (wcnt >= wait_n);
    imem_bus.imem_data = mem_word(imem_bus.imem_addr);
  end

  // Monitor: compares each accepted head entry and checks address hold.
  always @(negedge clock) begin
    if (!reset && instr_valid && consume && !branch_taken) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pop actual_pc=0x%0h expected=none", instr_pc);
      end else begin
        exp_pc = exp_q.pop_front();
        checkOutput("pop_pc", 32'(instr_pc), 32'(exp_pc));
        checkOutput("pop_instr", instruction, mem_word(32'(exp_pc)));
        pop_cyc.push_back(cycle);
      end
    end
    if (!reset && prev_re && !prev_ack && imem_bus.imem_re) begin
      checkOutput("addr_hold", imem_bus.imem_addr, prev_addr);
    end
    prev_re   = reset ? 1'b0 : imem_bus.imem_re;
    prev_ack  = imem_bus.imem_ack;
    prev_addr = imem_bus.imem_addr;
  end

  // Watchdog so a stuck design still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    int found;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, '0);

    $display("[TB] reset values and first request");
    wait_n = 0;
    applyReset();
    @(negedge clock);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_instr", instruction, NOOP);
    checkOutput("rst_pc", 32'(instr_pc), 32'd0);
    checkOutput("rst_re", 32'(imem_bus.imem_re), 32'd0);
    checkOutput("rst_addr", imem_bus.imem_addr, 32'd0);
    @(negedge clock);
    checkOutput("first_re", 32'(imem_bus.imem_re), 32'd1);
    checkOutput("first_addr", imem_bus.imem_addr, 32'd0);
    checkOutput("first_valid", 32'(instr_valid), 32'd0);

    $display("[TB] zero-wait streaming");
    pop_cyc.delete();
    pushRange(0, 8);
    @(posedge clock);
    #1;
    drainQueue(40);
    checkOutput("stream_pops", 32'(pop_cyc.size()), 32'd8);
    if (pop_cyc.size() == 8) checkOutput("stream_spacing", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);

    $display("[TB] two wait states");
    wait_n = 2;
    applyReset();
    pop_cyc.delete();
    pushRange(0, 6);
    drainQueue(60);
    checkOutput("wait_pops", 32'(pop_cyc.size()), 32'd6);
    if (pop_cyc.size() == 6) checkOutput("wait_spacing", 32'(pop_cyc[5] - pop_cyc[0]), 32'd15);

    $display("[TB] fill without consume");
    wait_n = 0;
    applyReset();
    repeat (8) @(negedge clock);
    checkOutput("full_re", 32'(imem_bus.imem_re), 32'd0);
    checkOutput("full_valid", 32'(instr_valid), 32'd1);
    checkOutput("full_pc", 32'(instr_pc), 32'd0);
    exp_q.push_back(PC_W'(0));
    @(posedge clock);
    #1 consume = 1'b1;
    @(posedge clock);
    #1 consume = 1'b0;
    @(negedge clock);
    checkOutput("restart_re", 32'(imem_bus.imem_re), 32'd1);
    checkOutput("restart_addr", imem_bus.imem_addr, 32'd16);
    pushRange(4, 4);
    @(posedge clock);
    #1;
    drainQueue(20);

    $display("[TB] branch while read pending");
    wait_n = 2;
    applyReset();
    pushRange(0, 2);
    drainQueue(30);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clock);
      if (imem_bus.imem_re && imem_bus.imem_addr == 32'd8 && !imem_bus.imem_ack) found = 1;
    end
    checkOutput("pend8_found", 32'(found), 32'd1);
    #1 applyStimulus(1'b0, 1'b1, PC_W'(12'h100));
    @(posedge clock);
    #1 applyStimulus(1'b0, 1'b0, '0);
    @(negedge clock);
    checkOutput("drain_re", 32'(imem_bus.imem_re), 32'd1);
    checkOutput("drain_addr", imem_bus.imem_addr, 32'd8);
    checkOutput("drain_valid", 32'(instr_valid), 32'd0);
    @(negedge clock);
    checkOutput("redirect_addr", imem_bus.imem_addr, 32'h100);
    pushRange(32'h100, 3);
    @(posedge clock);
    #1;
    drainQueue(40);

    $display("[TB] branch with ack and consume");
    wait_n = 0;
    applyReset();
    @(posedge clock);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    checkOutput("pre_valid", 32'(instr_valid), 32'd1);
    checkOutput("pre_pc", 32'(instr_pc), 32'd0);
    checkOutput("pre_ack", 32'(imem_bus.imem_ack), 32'd1);
    #1 applyStimulus(1'b1, 1'b1, PC_W'(12'h202));
    @(posedge clock);
    #1 applyStimulus(1'b0, 1'b0, '0);
    @(negedge clock);
    checkOutput("flush_valid", 32'(instr_valid), 32'd0);
    checkOutput("flush_instr", instruction, NOOP);
    checkOutput("flush_pc", 32'(instr_pc), 32'd0);
    checkOutput("flush_re", 32'(imem_bus.imem_re), 32'd1);
    checkOutput("flush_addr", imem_bus.imem_addr, 32'h200);
    pushRange(32'h200, 2);
    @(posedge clock);
    #1;
    drainQueue(20);

    $display("[TB] address wrap");
    wait_n = 0;
    applyReset();
    applyStimulus(1'b0, 1'b1, PC_W'(12'hFF8));
    @(posedge clock);
    #1 applyStimulus(1'b0, 1'b0, '0);
    @(negedge clock);
    checkOutput("wrap_addr", imem_bus.imem_addr, 32'hFF8);
    pushRange(32'hFF8, 4);
    @(posedge clock);
    #1;
    drainQueue(20);

    $display("[TB] reset mid-request");
    wait_n = 0;
    applyReset();
    @(posedge clock);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    checkOutput("mid_valid", 32'(instr_valid), 32'd1);
    checkOutput("mid_re", 32'(imem_bus.imem_re), 32'd1);
    #1 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkOutput("mid_rst_re", 32'(imem_bus.imem_re), 32'd0);
    checkOutput("mid_rst_addr", imem_bus.imem_addr, 32'd0);
    checkOutput("mid_rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("mid_rst_instr", instruction, NOOP);
    checkOutput("mid_rst_pc", 32'(instr_pc), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);

    checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
